// File: rtl/ffs_pkg.sv
// Shared types and defaults for the multi-cycle find-first-set engine.
// With FFS_SCAN_MSB_EN defined, the engine can also search from the MSB.
package ffs_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } ffs_state_t;

  localparam int unsigned FFS_WIDTH = 32;
  localparam int unsigned FFS_CHUNK = 8;

  function automatic int unsigned ffs_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/ffs_chunk.sv
// Combinational bit-index encoder for a single chunk: hit flag plus local index.
// With FFS_SCAN_MSB_EN defined, the msb input selects highest-set-bit mode.
module ffs_chunk #(
  parameter int unsigned CHUNK = 8,
  localparam int unsigned LW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
`ifdef FFS_SCAN_MSB_EN
  input  logic             msb,
`endif
  input  logic [CHUNK-1:0] din,
  output logic             hit,
  output logic [LW-1:0]    idx
);

  always_comb begin
    hit = |din;
    idx = '0;
`ifdef FFS_SCAN_MSB_EN
    if (msb) begin
      // Ascending walk: the last set bit seen is the highest.
      for (int i = 0; i < int'(CHUNK); i++) begin
        if (din[i]) idx = LW'(i);
      end
    end else begin
      for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
        if (din[i]) idx = LW'(i);
      end
    end
`else
    // Descending walk: the last set bit seen is the lowest.
    for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
      if (din[i]) idx = LW'(i);
    end
`endif
  end

endmodule

// File: rtl/ffs_scan.sv
// Multi-cycle find-first-set: scans a latched vector CHUNK bits per cycle.
// Optional FFS_SCAN_MSB_EN adds msb_first for a top-down highest-set-bit search.
module ffs_scan
  import ffs_pkg::*;
#(
  parameter int unsigned WIDTH = FFS_WIDTH,
  parameter int unsigned CHUNK = FFS_CHUNK,
  localparam int unsigned IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef FFS_SCAN_MSB_EN
  input  logic             msb_first,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_zero
);

  localparam int unsigned NCH = ffs_chunks(WIDTH, CHUNK);
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  ffs_state_t       state;
  logic [WIDTH-1:0] data;
  logic [KW-1:0]    k;
  logic [KW-1:0]    pos;
  logic [CHUNK-1:0] cur;
  logic             hit;
  logic [LW-1:0]    loc;
  logic [IDXW-1:0]  hit_idx;
  logic             last;

`ifdef FFS_SCAN_MSB_EN
  logic msb_q;
  assign pos = msb_q ? (KW'(NCH - 1) - k) : k;
`else
  assign pos = k;
`endif

  assign in_ready = (state == S_IDLE);
  assign cur      = data[int'(pos) * int'(CHUNK) +: CHUNK];
  assign last     = (k == KW'(NCH - 1));
  assign hit_idx  = IDXW'(int'(pos) * int'(CHUNK) + int'(loc));

  ffs_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
`ifdef FFS_SCAN_MSB_EN
    .msb (msb_q),
`endif
    .din (cur),
    .hit (hit),
    .idx (loc)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      k         <= '0;
      data      <= '0;
`ifdef FFS_SCAN_MSB_EN
      msb_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            k     <= '0;
`ifdef FFS_SCAN_MSB_EN
            msb_q <= msb_first;
`endif
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit) begin
            out_idx   <= hit_idx;
            out_zero  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (last) begin
            out_idx   <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffs_scan.sv
// Directed self-checking bench for ffs_scan at WIDTH=32, CHUNK=8.
// Covers the msb_first port too when built with FFS_SCAN_MSB_EN.
module tb_ffs_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_zero;
`ifdef FFS_SCAN_MSB_EN
  logic        msb_first;
`endif

  int checks   = 0;
  int failures = 0;

  ffs_scan #(
    .WIDTH(32),
    .CHUNK(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef FFS_SCAN_MSB_EN
    .msb_first (msb_first),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one vector at E0, wait for the result, check latency and payload, then retire it.
  task automatic run_vec(input string tag, input logic [31:0] vec, input logic msb,
                         input logic [4:0] exp_idx, input logic exp_zero, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = vec;
`ifdef FFS_SCAN_MSB_EN
    msb_first = msb;
`else
    if (msb) $display("note: msb_first unavailable in this build");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hdead_beef;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_idx"}, 32'(out_idx), 32'(exp_idx));
    check({tag, "_out_zero"}, 32'(out_zero), 32'(exp_zero));
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_retired_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_retired_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FFS_SCAN_MSB_EN
    msb_first = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_vec("lsb0", 32'h0000_0001, 1'b0, 5'd0, 1'b0, 1);
    run_vec("msb31", 32'h8000_0000, 1'b0, 5'd31, 1'b0, 4);
    run_vec("zero", 32'h0000_0000, 1'b0, 5'd0, 1'b1, 4);
    run_vec("mid", 32'h0001_0100, 1'b0, 5'd8, 1'b0, 2);
    run_vec("c2", 32'h00f0_0000, 1'b0, 5'd20, 1'b0, 3);
`ifdef FFS_SCAN_MSB_EN
    run_vec("mid_msb", 32'h0001_0100, 1'b1, 5'd16, 1'b0, 2);
    run_vec("top_msb", 32'h8000_0001, 1'b1, 5'd31, 1'b0, 1);
    run_vec("zero_msb", 32'h0000_0000, 1'b1, 5'd0, 1'b1, 4);
    msb_first = 1'b0;
`endif

    // Hold the result with out_ready low; an in_valid pulse in this window must be ignored.
    in_valid = 1'b1;
    in_data  = 32'h0000_0400;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("hold_first_idx", 32'(out_idx), 32'd10);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_idx", 32'(out_idx), 32'd10);
      check("hold_zero", 32'(out_zero), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("hold_ignored_pulse", 32'(out_valid), 32'd0);
    end

    // Leave a zero result registered so reset clearing out_zero is observable.
    run_vec("prezero", 32'h0000_0000, 1'b0, 5'd0, 1'b1, 4);

    // Reset in the middle of a worst-case scan.
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midscan_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    run_vec("post_rst", 32'h0200_0000, 1'b0, 5'd25, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
